// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM states, requester IDs and
// active-low strobe levels.
package sram_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic PORT_CPU   = 1'b0;
   localparam logic PORT_DBG   = 1'b1;
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;
   localparam int   CNT_W      = 3;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter. The arbiter uses the slave
// modport; requesters and the SRAM model see the master view.
interface sram_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              dbg_req, dbg_we, dbg_ack;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
   logic [DATA_W-1:0] sram_rdata, sram_wdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              SRAM_CS, SRAM_write, SRAM_OE, sram_drive;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, sram_rdata,
      output cpu_rdata, cpu_ack, cpu_stall, dbg_rdata, dbg_ack,
      output SRAM_CS, SRAM_write, SRAM_OE, sram_addr, sram_wdata, sram_drive
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, sram_rdata,
      input  cpu_rdata, cpu_ack, cpu_stall, dbg_rdata, dbg_ack,
      input  SRAM_CS, SRAM_write, SRAM_OE, sram_addr, sram_wdata, sram_drive
   );
endinterface

// File: rtl/sram_arbiter_rr_grant2.sv
// Two-way round-robin grant. last_grant doubles as the owner of the
// transaction in flight, since it only changes on a grant.
module rr_grant2
   import sram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] grant,
   output logic       last_grant
);
   always_comb begin
      grant = 2'b00;
      if (grant_en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // Reset to DBG so the CPU wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        last_grant <= PORT_DBG;
      else if (|grant) last_grant <= grant[PORT_DBG];
   end
endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-ported data SRAM between the CPU and debug loader,
// sequencing each access as SETUP / ACCESS x (WAIT_CYCLES+1) / FINISH.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input logic           clk,
   input logic           rst,
   sram_arbiter_if.slave bus
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_t            state_q, state_d;
   logic [1:0]        req, grant;
   logic              grant_en, owner;
   req_t              cpu_r, dbg_r, cur_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
   logic              cpu_ack, dbg_ack;
   logic              access_last;

   assign req         = {bus.dbg_req, bus.cpu_req};
   assign grant_en    = (state_q == IDLE);
   assign access_last = (state_q == ACCESS) && (cnt_q == '0);
   assign cpu_r       = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
   assign dbg_r       = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};

   rr_grant2 u_rr (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .grant_en   (grant_en),
      .grant      (grant),
      .last_grant (owner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (cnt_q == '0) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.SRAM_CS    = STROBE_OFF;
      bus.SRAM_write = STROBE_OFF;
      bus.SRAM_OE    = STROBE_OFF;
      bus.sram_drive = 1'b0;
      cpu_ack        = 1'b0;
      dbg_ack        = 1'b0;
      case (state_q)
         SETUP: begin
            bus.SRAM_CS    = STROBE_ON;
            bus.sram_drive = cur_q.we;
         end
         ACCESS: begin
            bus.SRAM_CS    = STROBE_ON;
            bus.sram_drive = cur_q.we;
            if (cur_q.we) bus.SRAM_write = STROBE_ON;
            else          bus.SRAM_OE    = STROBE_ON;
         end
         FINISH: begin
            cpu_ack = (owner == PORT_CPU);
            dbg_ack = (owner == PORT_DBG);
         end
         default: ;
      endcase
   end

   // Requester inputs are sampled only on the grant edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q <= '0;
         cnt_q <= '0;
      end else begin
         if (|grant)                    cur_q <= grant[PORT_DBG] ? dbg_r : cpu_r;
         if (state_q == SETUP)          cnt_q <= WAIT_LD;
         else if (state_q == ACCESS && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else if (access_last && !cur_q.we) begin
         if (owner == PORT_DBG) dbg_rdata_q <= bus.sram_rdata;
         else                   cpu_rdata_q <= bus.sram_rdata;
      end
   end

   assign bus.sram_addr  = cur_q.addr;
   assign bus.sram_wdata = cur_q.wdata;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
   assign bus.cpu_ack    = cpu_ack;
   assign bus.dbg_ack    = dbg_ack;
   assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table with a read-data scoreboard, SRAM model,
// plus hand sequences for contention, request drop, reset abort and wait builds.
module tb_sram_arbiter;
   logic clk, rst;
   int   checks = 0, errors = 0;

   sram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus  ();
   sram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus0 ();
   sram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus7 ();

   sram_arbiter #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
   sram_arbiter #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .rst(rst), .bus(bus0));
   sram_arbiter #(.ADDR_W(11), .DATA_W(32), .WAIT_CYCLES(7)) dut_w7 (.clk(clk), .rst(rst), .bus(bus7));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: writes land on the clock edge while CS and WE are low.
   logic [31:0] mem [0:2047];
   always @(posedge clk) if (!bus.SRAM_CS && !bus.SRAM_write) mem[bus.sram_addr] <= bus.sram_wdata;
   assign bus.sram_rdata  = !bus.SRAM_OE ? mem[bus.sram_addr] : 32'h0BAD0BAD;
   assign bus0.sram_rdata = '0;
   assign bus7.sram_rdata = '0;

   int cs_lo = 0, wr_lo = 0, oe_lo = 0, dv_hi = 0, cpu_acks = 0, dbg_acks = 0, overlap = 0;
   always @(negedge clk) begin
      if (!bus.SRAM_CS)    cs_lo++;
      if (!bus.SRAM_write) wr_lo++;
      if (!bus.SRAM_OE)    oe_lo++;
      if (bus.sram_drive)  dv_hi++;
      if (bus.cpu_ack)     cpu_acks++;
      if (bus.dbg_ack)     dbg_acks++;
      if (!bus.SRAM_write && !bus.SRAM_OE) overlap++;
   end

   logic [31:0] sb [$];
   logic [31:0] last_rd [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic txn(input bit p, input bit we, input logic [10:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
      int n, st, cs0, wr0, oe0, dv0;
      logic ack;
      logic [31:0] rd, e;
      @(negedge clk);
      cs0 = cs_lo; wr0 = wr_lo; oe0 = oe_lo; dv0 = dv_hi;
      if (p) begin bus.dbg_req = 1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d; end
      else   begin bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
      if (!we) sb.push_back(exp);
      n = 0; st = 0; ack = 0;
      while (!ack && n < 40) begin
         @(negedge clk); n++;
         ack = p ? bus.dbg_ack : bus.cpu_ack;
         if (!ack && !p && bus.cpu_stall) st++;
      end
      chk("latency", n, 4);
      if (!p) begin
         chk("stall_cycles", st, 3);
         chk("stall_at_ack", bus.cpu_stall, 0);
      end
      rd = p ? bus.dbg_rdata : bus.cpu_rdata;
      if (!we) begin
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            chk("rdata", rd, e);
            last_rd[p] = e;
         end
      end else chk("rdata_kept", rd, last_rd[p]);
      if (p) bus.dbg_req = 0; else bus.cpu_req = 0;
      @(negedge clk);
      chk("cs_low", cs_lo - cs0, 3);
      chk("wr_low", wr_lo - wr0, we ? 2 : 0);
      chk("oe_low", oe_lo - oe0, we ? 0 : 2);
      chk("drive", dv_hi - dv0, we ? 3 : 0);
      if (we) chk("mem", mem[a], d);
   endtask

   typedef struct {
      bit          p;
      bit          we;
      logic [10:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [10];

   initial begin
      int n, k, c0, l0, l7;
      bit d0, d7;
      int ord [5];
      int at  [5];

      vecs[0] = '{0, 1, 11'h005, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{0, 0, 11'h005, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1, 1, 11'h7FE, 32'h12345678, 32'h0};
      vecs[3] = '{1, 0, 11'h7FE, 32'h0,        32'h12345678};
      vecs[4] = '{0, 0, 11'h7FE, 32'h0,        32'h12345678};
      vecs[5] = '{1, 1, 11'h7FF, 32'hCAFEF00D, 32'h0};
      vecs[6] = '{0, 1, 11'h000, 32'h00000000, 32'h0};
      vecs[7] = '{1, 1, 11'h005, 32'hA5A55A5A, 32'h0};
      vecs[8] = '{0, 0, 11'h005, 32'h0,        32'hA5A55A5A};
      vecs[9] = '{1, 0, 11'h7FF, 32'h0,        32'hCAFEF00D};
      last_rd[0] = '0; last_rd[1] = '0;

      rst = 0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      bus0.cpu_req = 0; bus0.cpu_we = 1; bus0.cpu_addr = 11'h001; bus0.cpu_wdata = 32'h1;
      bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = '0; bus0.dbg_wdata = '0;
      bus7.cpu_req = 0; bus7.cpu_we = 1; bus7.cpu_addr = 11'h001; bus7.cpu_wdata = 32'h1;
      bus7.dbg_req = 0; bus7.dbg_we = 0; bus7.dbg_addr = '0; bus7.dbg_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_cs", bus.SRAM_CS, 1);
      chk("rst_we", bus.SRAM_write, 1);
      chk("rst_oe", bus.SRAM_OE, 1);
      chk("rst_cpu_ack", bus.cpu_ack, 0);
      chk("rst_dbg_ack", bus.dbg_ack, 0);
      chk("rst_stall", bus.cpu_stall, 0);
      chk("rst_drive", bus.sram_drive, 0);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 0);

      // Both ports request together straight after reset: cpu first, then alternate.
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h010; bus.cpu_wdata = 32'h11111111;
      bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 11'h011; bus.dbg_wdata = 32'h22222222;
      n = 0; k = 0;
      while (k < 4 && n < 60) begin
         @(negedge clk); n++;
         if (bus.cpu_ack && k < 5) begin ord[k] = 0; at[k] = n; k++; end
         if (bus.dbg_ack && k < 5) begin ord[k] = 1; at[k] = n; k++; end
      end
      bus.cpu_req = 0; bus.dbg_req = 0;
      chk("rr_acks", k, 4);
      for (int i = 0; i < 4 && i < k; i++) begin
         chk("rr_order", ord[i], i % 2);
         chk("rr_ack_cycle", at[i], 4 + 5 * i);
      end
      @(negedge clk);
      chk("rr_mem_cpu", mem[11'h010], 32'h11111111);
      chk("rr_mem_dbg", mem[11'h011], 32'h22222222);

      for (int i = 0; i < 10; i++) txn(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp);

      // dbg drops its request one cycle after the grant.
      @(negedge clk);
      c0 = dbg_acks;
      bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 11'h020; bus.dbg_wdata = 32'h33333333;
      @(negedge clk);
      chk("drop_granted_cs", bus.SRAM_CS, 0);
      bus.dbg_req = 0;
      n = 1;
      while (!bus.dbg_ack && n < 40) begin @(negedge clk); n++; end
      chk("drop_latency", n, 4);
      repeat (6) @(negedge clk);
      chk("drop_one_ack", dbg_acks - c0, 1);
      chk("drop_idle_cs", bus.SRAM_CS, 1);
      chk("drop_mem", mem[11'h020], 32'h33333333);

      // Reset asserted mid-ACCESS aborts the write with no ack.
      @(negedge clk);
      c0 = cpu_acks;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h030; bus.cpu_wdata = 32'h44444444;
      repeat (2) @(negedge clk);
      chk("pre_rst_wr", bus.SRAM_write, 0);
      rst = 0;
      #1;
      chk("abort_cs", bus.SRAM_CS, 1);
      chk("abort_we", bus.SRAM_write, 1);
      chk("abort_oe", bus.SRAM_OE, 1);
      chk("abort_drive", bus.sram_drive, 0);
      chk("abort_ack", bus.cpu_ack, 0);
      chk("abort_rdata", bus.cpu_rdata, 0);
      @(negedge clk);
      bus.cpu_req = 0;
      @(negedge clk);
      rst = 1;
      repeat (8) @(negedge clk);
      chk("abort_no_ack", cpu_acks - c0, 0);
      last_rd[0] = '0; last_rd[1] = '0;

      // Latency of the WAIT_CYCLES = 0 and 7 builds.
      bus0.cpu_req = 1; bus7.cpu_req = 1;
      n = 0; d0 = 0; d7 = 0; l0 = 0; l7 = 0;
      while ((!d0 || !d7) && n < 30) begin
         @(negedge clk); n++;
         if (bus0.cpu_ack && !d0) begin l0 = n; d0 = 1; bus0.cpu_req = 0; end
         if (bus7.cpu_ack && !d7) begin l7 = n; d7 = 1; bus7.cpu_req = 0; end
      end
      bus0.cpu_req = 0; bus7.cpu_req = 0;
      chk("lat_w0", l0, 3);
      chk("lat_w7", l7, 10);

      chk("strobe_overlap", overlap, 0);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-ported data SRAM between two requesters: the CPU load/store path (port cpu) and the debug/program loader (port dbg).
- Sequences each access as a multi-cycle SRAM cycle (setup, access, finish) and drives the SRAM control strobes.
- Drives cpu_stall, which feeds the control unit's controlSuspend input so the program counter holds while a CPU access is outstanding.
- Sits between control_top and the SRAM, replacing direct SRAM_CS/SRAM_write generation.

Parameters:
- ADDR_W, 11: SRAM word-address width.
- DATA_W, 32: data width.
- WAIT_CYCLES, 1: extra ACCESS cycles beyond the first. Legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU request; level, held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU word address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_rdata  output  DATA_W  CPU read data, valid from cpu_ack onward.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  cpu_req & ~cpu_ack; combinational.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same definitions as the cpu_* ports, for the debug/loader port.
- sram_rdata  input  DATA_W  data returned by the SRAM.
- SRAM_CS  output  1  chip select, active-low.
- SRAM_write  output  1  write enable, active-low.
- SRAM_OE  output  1  output enable, active-low.
- sram_addr  output  ADDR_W  SRAM address.
- sram_wdata  output  DATA_W  data to the SRAM.
- sram_drive  output  1  tri-state enable for sram_wdata, active-high.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_grant = dbg, so the CPU wins the first tie.
  - SRAM_CS, SRAM_write and SRAM_OE = 1.
  - sram_addr, sram_wdata, sram_drive, both acks and both rdata outputs = 0.
  - A reset mid-transaction aborts it; no ack is issued.
- State encoding: IDLE = 0, SETUP = 1, ACCESS = 2, FINISH = 3.
- IDLE:
  - At a rising edge with any request high, grant and go to SETUP.
  - If both requests are high, grant the requester other than last_grant (2-way round-robin). last_grant updates on grant.
  - On grant, latch the granted requester's addr, we and wdata. Requester inputs are ignored after the grant.
- SETUP (1 cycle):
  - SRAM_CS = 0 and sram_addr = latched address.
  - Write: sram_wdata = latched data, sram_drive = 1.
- ACCESS (WAIT_CYCLES + 1 cycles, counted by a down-counter of width 3):
  - SRAM_CS = 0.
  - Write: SRAM_write = 0, sram_drive = 1.
  - Read: SRAM_OE = 0. sram_rdata is captured into the granted port's rdata register at the edge that leaves ACCESS.
- FINISH (1 cycle):
  - All strobes return high and sram_drive = 0; sram_addr holds its value.
  - The granted port's ack = 1.
  - Next state is IDLE, unconditionally. No grant is made in FINISH.
- Latency:
  - Take the grant edge as E0. The ack is high during the cycle after edge E(WAIT_CYCLES + 2).
  - With WAIT_CYCLES = 1, the ack is high in the 4th cycle.
  - Minimum spacing between grants is WAIT_CYCLES + 4 cycles.
- Read data:
  - rdata holds until the next read completes on the same port.
  - Writes never alter rdata.
- Request handshake:
  - A requester that still has req high in the cycle after its ack is issuing a new request.
  - If a request drops before its ack, the transaction still completes and the ack still pulses.
- Fairness: with both ports continuously requesting, grants alternate cpu, dbg, cpu, and so on.
- Strobe glitches: SRAM_write and SRAM_OE are never both low. No strobe may be low while state is IDLE.

Decomposition:
- Shared package (header): state encodings, port IDs (CPU = 0, DBG = 1), and active-low strobe constants.
- Sub-module rr_grant2:
  - Inputs: req[1:0], last_grant, grant_en.
  - Outputs: one-hot grant[1:0], and a registered last_grant.
  - About 40 lines.

Test Plan:
1. Reset with all inputs idle: all strobes = 1, acks = 0, cpu_stall = 0. Asserting rst low mid-ACCESS returns the strobes high immediately and no ack is issued.
2. CPU write with cpu_addr = 0x005, cpu_wdata = 0xDEADBEEF, WAIT_CYCLES = 1:
   - SRAM_CS is low for 3 cycles and SRAM_write is low for 2.
   - sram_drive is high for 3 cycles.
   - cpu_ack pulses in cycle 4 and cpu_stall is high for cycles 1–3.
3. CPU read of 0x005 with a model returning 0xDEADBEEF: cpu_rdata = 0xDEADBEEF when cpu_ack is high. SRAM_write stays high throughout.
4. cpu_req and dbg_req rise on the same edge straight after reset:
   - CPU is granted first and dbg_ack follows cpu_ack by WAIT_CYCLES + 4 cycles.
   - Keeping both requests high gives the grant order cpu, dbg, cpu, dbg.
5. dbg_req is dropped one cycle after its grant: the transaction completes, dbg_ack still pulses, and the state returns to IDLE.
6. WAIT_CYCLES = 0 and WAIT_CYCLES = 7 builds: the ack lands in cycle 3 and cycle 10 respectively after the grant edge.
